mac_array: RTL and testbench

MAC_ARRAY -- requirements
Module: mac_array

---
 rtl/mac_array_pkg.sv | 35 +++
 rtl/mac_array_mul_seq.sv | 75 +++++++
 rtl/mac_array.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_mac_array.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_array_pkg.sv
// ---------------------------------------------------------------------------
// mac_array_pkg
// Shared definitions for the MAC array: controller state encoding, default
// parameter values and the accumulator guard-bit count.
// Optional build macro used by the design: MAC_ARRAY_SAT_EN (saturating
// accumulators with sticky overflow flags).
// ---------------------------------------------------------------------------
package mac_array_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_N_ROWS     = 2;
    localparam int DEF_KMEM_DEPTH = 2304;
    localparam int DEF_FRAC_W     = 8;

    // Extra accumulator bits above the full product width, so that a few
    // accumulations of full-scale products do not overflow.
    localparam int GUARD_W = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GET_BIAS  = 3'd1,
        INIT_BIAS = 3'd2,
        SKIP      = 3'd3,
        MUL_RUN   = 3'd4,
        MUL_WAIT  = 3'd5,
        ACC       = 3'd6,
        KWRITE    = 3'd7
    } state_t;

    // Address/select width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/mac_array_mul_seq.sv
// ---------------------------------------------------------------------------
// mac_mul_seq
// Sequential signed shift-add multiplier. One multiplier bit is consumed per
// clock; the final (sign) bit carries negative weight, so its partial
// product is subtracted.
//
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset, aborts any multiplication
//   start   : pulse; operands a/b are captured on this edge
//   a, b    : signed DATA_W operands (multiplicand, multiplier)
//   done    : one-cycle pulse, high DATA_W cycles after the start cycle
//   product : signed 2*DATA_W result, valid while done is high and held after
// ---------------------------------------------------------------------------
module mac_mul_seq #(
    parameter int  DATA_W = 16,
    localparam int PROD_W = 2 * DATA_W,
    localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    logic [PROD_W-1:0] mcand_reg;
    logic [PROD_W-1:0] prod_reg;
    logic [DATA_W-1:0] mplier_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              run_reg;
    logic              done_reg;

    logic              last_bit;
    logic [PROD_W-1:0] partial;

    assign last_bit = (cnt_reg == CNT_W'(DATA_W - 1));
    assign partial  = mplier_reg[0] ? mcand_reg : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_reg  <= '0;
            prod_reg   <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            run_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                mcand_reg  <= {{DATA_W{a[DATA_W-1]}}, a};
                mplier_reg <= b;
                prod_reg   <= '0;
                cnt_reg    <= '0;
                run_reg    <= 1'b1;
            end else if (run_reg) begin
                // Two's complement: bit DATA_W-1 weighs -2^(DATA_W-1).
                prod_reg   <= last_bit ? (prod_reg - partial) : (prod_reg + partial);
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg + CNT_W'(1);
                if (last_bit) begin
                    run_reg  <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign done    = done_reg;
    assign product = prod_reg;

endmodule

// File: rtl/mac_array.sv
// ---------------------------------------------------------------------------
// mac_array
// Multiply-accumulate engine: a pixel is multiplied by a word from the kernel
// memory and added into one of N_ROWS accumulators. Accumulators can be
// preset from a bias word; each row is presented as a fixed-point quantized
// DATA_W result.
//
// Build macro: MAC_ARRAY_SAT_EN -- when defined, accumulation saturates at
// the signed ACC_W limits and sets a sticky per-row sat_flag; otherwise the
// accumulators wrap and sat_flag reads 0.
//
// Ports
//   clk            : clock, rising edge
//   rst            : asynchronous active-high reset (kernel memory is kept)
//   px_val         : signed pixel operand
//   kern_addr      : kernel memory address (write, bias load, MAC operand)
//   kern_wdata     : kernel write data
//   kern_wmode     : level, requests kernel-write mode
//   kern_we        : write strobe while in kernel-write mode
//   bias_load      : pulse, bias <= kmem[kern_addr]
//   row_sel        : target accumulator for the MAC
//   mac_start      : pulse, start a MAC
//   mac_start_bias : pulse, preset all rows to the bias, then MAC
//   busy           : high whenever the controller is not idle
//   done           : one-cycle completion pulse
//   result_px      : quantized rows, row 0 in the LSBs
//   sat_flag       : sticky per-row saturation flags
// ---------------------------------------------------------------------------
module mac_array
    import mac_array_pkg::*;
#(
    parameter int  DATA_W     = DEF_DATA_W,
    parameter int  N_ROWS     = DEF_N_ROWS,
    parameter int  KMEM_DEPTH = DEF_KMEM_DEPTH,
    parameter int  FRAC_W     = DEF_FRAC_W,
    localparam int KADDR_W    = $clog2(KMEM_DEPTH),
    localparam int ACC_W      = 2 * DATA_W + GUARD_W,
    localparam int ROW_W      = clog2_min1(N_ROWS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        px_val,
    input  logic [KADDR_W-1:0]       kern_addr,
    input  logic [DATA_W-1:0]        kern_wdata,
    input  logic                     kern_wmode,
    input  logic                     kern_we,
    input  logic                     bias_load,
    input  logic [ROW_W-1:0]         row_sel,
    input  logic                     mac_start,
    input  logic                     mac_start_bias,
    output logic                     busy,
    output logic                     done,
    output logic [N_ROWS*DATA_W-1:0] result_px,
    output logic [N_ROWS-1:0]        sat_flag
);

    localparam logic [ACC_W-1:0]  ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]  ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] Q_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] Q_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

    // -----------------------------------------------------------------------
    // Controller state and latched operands
    // -----------------------------------------------------------------------
    state_t                   state_reg;
    logic                     busy_reg;
    logic                     done_reg;
    logic [DATA_W-1:0]        px_reg;
    logic [DATA_W-1:0]        kop_reg;
    logic [DATA_W-1:0]        bias_reg;
    logic [ROW_W-1:0]         row_reg;
    logic [KADDR_W-1:0]       addr_reg;
    logic signed [ACC_W-1:0]  acc_reg [N_ROWS];
`ifdef MAC_ARRAY_SAT_EN
    logic [N_ROWS-1:0]        sat_reg;
`endif

    // -----------------------------------------------------------------------
    // Kernel memory. Not reset, so its contents survive rst. The read is
    // combinational because the MAC operand has to be captured (and tested
    // for zero) on the very edge that accepts the command.
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0]  kmem [KMEM_DEPTH];
    logic [KADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0]  rd_data;
    logic               wr_in_range;
    logic               kmem_we;

    assign rd_addr     = (state_reg == GET_BIAS) ? addr_reg : kern_addr;
    assign rd_data     = (32'(rd_addr) < KMEM_DEPTH) ? kmem[rd_addr] : '0;
    assign wr_in_range = (32'(kern_addr) < KMEM_DEPTH);
    assign kmem_we     = (state_reg == KWRITE) && kern_we && wr_in_range;

    always_ff @(posedge clk) begin
        if (kmem_we) begin
            kmem[kern_addr] <= kern_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Multiplier
    // -----------------------------------------------------------------------
    logic                  mul_start;
    logic                  mul_done;
    logic [2*DATA_W-1:0]   mul_product;

    assign mul_start = (state_reg == MUL_RUN);

    mac_mul_seq #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (px_reg),
        .b       (kop_reg),
        .done    (mul_done),
        .product (mul_product)
    );

    // -----------------------------------------------------------------------
    // Accumulate datapath: a single adder shared by all rows.
    // -----------------------------------------------------------------------
    logic [ACC_W-1:0] acc_sel;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] acc_new;
    logic [ACC_W-1:0] bias_ext;
    logic             start_zero;
    logic             latched_zero;

    always_comb begin
        acc_sel = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            if (ROW_W'(r) == row_reg) begin
                acc_sel = acc_reg[r];
            end
        end
    end

    assign prod_ext = {{GUARD_W{mul_product[2*DATA_W-1]}}, mul_product};
    assign bias_ext = {{(ACC_W-DATA_W){bias_reg[DATA_W-1]}}, bias_reg};

`ifdef MAC_ARRAY_SAT_EN
    logic [ACC_W:0] acc_sum;
    logic           acc_ovf;

    // One extra bit: the two top bits disagree exactly on signed overflow.
    assign acc_sum = {acc_sel[ACC_W-1], acc_sel} + {prod_ext[ACC_W-1], prod_ext};
    assign acc_ovf = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
    assign acc_new = acc_ovf ? (acc_sum[ACC_W] ? ACC_MIN : ACC_MAX) : acc_sum[ACC_W-1:0];
`else
    assign acc_new = acc_sel + prod_ext;
`endif

    assign start_zero   = (px_val == '0) || (rd_data == '0);
    assign latched_zero = (px_reg == '0) || (kop_reg == '0);

    // -----------------------------------------------------------------------
    // Controller. busy/done are registered alongside the state they belong
    // to: busy for every non-IDLE state, done for SKIP and ACC.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            px_reg    <= '0;
            kop_reg   <= '0;
            bias_reg  <= '0;
            row_reg   <= '0;
            addr_reg  <= '0;
            for (int r = 0; r < N_ROWS; r++) begin
                acc_reg[r] <= '0;
            end
`ifdef MAC_ARRAY_SAT_EN
            sat_reg   <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (mac_start) begin
                        px_reg    <= px_val;
                        kop_reg   <= rd_data;
                        row_reg   <= row_sel;
                        addr_reg  <= kern_addr;
                        busy_reg  <= 1'b1;
                        done_reg  <= start_zero;
                        state_reg <= start_zero ? SKIP : MUL_RUN;
                    end else if (mac_start_bias) begin
                        px_reg    <= px_val;
                        kop_reg   <= rd_data;
                        row_reg   <= row_sel;
                        addr_reg  <= kern_addr;
                        busy_reg  <= 1'b1;
                        state_reg <= INIT_BIAS;
                    end else if (bias_load) begin
                        addr_reg  <= kern_addr;
                        busy_reg  <= 1'b1;
                        state_reg <= GET_BIAS;
                    end else if (kern_wmode) begin
                        busy_reg  <= 1'b1;
                        state_reg <= KWRITE;
                    end
                end
                GET_BIAS: begin
                    bias_reg  <= rd_data;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                INIT_BIAS: begin
                    for (int r = 0; r < N_ROWS; r++) begin
                        acc_reg[r] <= bias_ext;
                    end
`ifdef MAC_ARRAY_SAT_EN
                    sat_reg   <= '0;
`endif
                    done_reg  <= latched_zero;
                    state_reg <= latched_zero ? SKIP : MUL_RUN;
                end
                SKIP: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                MUL_RUN: begin
                    state_reg <= MUL_WAIT;
                end
                MUL_WAIT: begin
                    if (mul_done) begin
                        done_reg  <= 1'b1;
                        state_reg <= ACC;
                    end
                end
                ACC: begin
                    // An out-of-range row matches no r and is left untouched.
                    for (int r = 0; r < N_ROWS; r++) begin
                        if (ROW_W'(r) == row_reg) begin
                            acc_reg[r] <= acc_new;
`ifdef MAC_ARRAY_SAT_EN
                            if (acc_ovf) begin
                                sat_reg[r] <= 1'b1;
                            end
`endif
                        end
                    end
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                KWRITE: begin
                    if (!kern_wmode) begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;

`ifdef MAC_ARRAY_SAT_EN
    assign sat_flag = sat_reg;
`else
    assign sat_flag = '0;
`endif

    // -----------------------------------------------------------------------
    // Output quantizer: drop FRAC_W fraction bits, clamp to DATA_W signed.
    // The value fits when every bit from DATA_W-1 upward equals the sign.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_ROWS; gi++) begin : g_row
            logic signed [ACC_W-1:0] shifted;
            logic                    fits;

            assign shifted = acc_reg[gi] >>> FRAC_W;
            assign fits    = (&shifted[ACC_W-1:DATA_W-1]) || !(|shifted[ACC_W-1:DATA_W-1]);
            assign result_px[gi*DATA_W +: DATA_W] =
                fits ? shifted[DATA_W-1:0] : (shifted[ACC_W-1] ? Q_MIN : Q_MAX);
        end
    endgenerate

endmodule

// File: tb/tb_mac_array.sv
// ---------------------------------------------------------------------------
// tb_mac_array
// Directed bench for mac_array (DATA_W=16, N_ROWS=2, FRAC_W=8). A second
// instance with N_ROWS=3 receives the same command stream so an out-of-range
// row select (3) can be expressed. Expected values are hand computed.
// ---------------------------------------------------------------------------
module tb_mac_array;

    logic        clk;
    logic        rst;
    logic [15:0] px_val;
    logic [11:0] kern_addr;
    logic [15:0] kern_wdata;
    logic        kern_wmode;
    logic        kern_we;
    logic        bias_load;
    logic        row_sel;
    logic [1:0]  row_sel3;
    logic        mac_start;
    logic        mac_start_bias;

    logic        busy,  done;
    logic [31:0] result_px;
    logic [1:0]  sat_flag;
    logic        busy3, done3;
    logic [47:0] result_px3;
    logic [2:0]  sat_flag3;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;
    int dcount;

    mac_array dut (
        .clk(clk), .rst(rst), .px_val(px_val), .kern_addr(kern_addr),
        .kern_wdata(kern_wdata), .kern_wmode(kern_wmode), .kern_we(kern_we),
        .bias_load(bias_load), .row_sel(row_sel), .mac_start(mac_start),
        .mac_start_bias(mac_start_bias), .busy(busy), .done(done),
        .result_px(result_px), .sat_flag(sat_flag)
    );

    mac_array #(.N_ROWS(3)) dut3 (
        .clk(clk), .rst(rst), .px_val(px_val), .kern_addr(kern_addr),
        .kern_wdata(kern_wdata), .kern_wmode(kern_wmode), .kern_we(kern_we),
        .bias_load(bias_load), .row_sel(row_sel3), .mac_start(mac_start),
        .mac_start_bias(mac_start_bias), .busy(busy3), .done(done3),
        .result_px(result_px3), .sat_flag(sat_flag3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // kind: 0 = mac_start, 1 = mac_start_bias, 2 = bias_load. Returns one
    // sample after the accepting edge.
    task automatic cmd(input int kind, input logic [15:0] px, input logic [11:0] addr,
                       input logic row, input logic [1:0] row3);
        px_val         = px;
        kern_addr      = addr;
        row_sel        = row;
        row_sel3       = row3;
        mac_start      = (kind == 0);
        mac_start_bias = (kind == 1);
        bias_load      = (kind == 2);
        step();
        mac_start      = 1'b0;
        mac_start_bias = 1'b0;
        bias_load      = 1'b0;
        px_val         = 16'h0;
    endtask

    // Counts clock edges until done is seen (bounded).
    task automatic wait_done(output int c);
        c = 0;
        while (done !== 1'b1 && c < 60) begin
            step();
            c++;
        end
    endtask

    task automatic kwrite(input logic [11:0] addr, input logic [15:0] data);
        kern_we    = 1'b1;
        kern_addr  = addr;
        kern_wdata = data;
        step();
        kern_we    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; px_val = '0; kern_addr = '0; kern_wdata = '0;
        kern_wmode = 1'b0; kern_we = 1'b0; bias_load = 1'b0; row_sel = 1'b0;
        row_sel3 = '0; mac_start = 1'b0; mac_start_bias = 1'b0;
        step(); step();

        // Reset state
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_result", {32'd0, result_px}, 64'd0);
        check("rst_sat", {62'd0, sat_flag}, 64'd0);
        rst = 1'b0;
        step();

        // Kernel memory load
        kern_wmode = 1'b1;
        step();
        check("kw_busy", {63'd0, busy}, 64'd1);
        kwrite(12'd5,    16'h0100);
        kwrite(12'd7,    16'h0080);
        kwrite(12'd9,    16'hFF00);
        kwrite(12'd11,   16'h7FFF);
        kwrite(12'd13,   16'h1234);
        kwrite(12'd3000, 16'hBEEF);
        kern_wmode = 1'b0;
        step();
        check("kw_idle", {63'd0, busy}, 64'd0);

        // Bias load from address 7
        cmd(2, 16'h0, 12'd7, 1'b0, 2'd0);
        check("gb_busy", {63'd0, busy}, 64'd1);
        step();
        check("gb_bias", {48'd0, dut.bias_reg}, 64'h80);
        check("gb_idle", {63'd0, busy}, 64'd0);

        // mac_start_bias: px 0x200 * kmem[5]=0x100 into row 0 over bias 0x80
        cmd(1, 16'h0200, 12'd5, 1'b0, 2'd0);
        wait_done(cyc);
        check("mb_lat", 64'(cyc), 64'd19);
        step();
        check("mb_acc0", {28'd0, dut.acc_reg[0]}, 64'h20080);
        check("mb_acc1", {28'd0, dut.acc_reg[1]}, 64'h80);
        check("mb_result", {32'd0, result_px}, 64'h0000_0200);
        check("mb_done_pulse", {63'd0, done}, 64'd0);

        // Zero pixel: SKIP, busy and done together for one cycle
        cmd(0, 16'h0000, 12'd5, 1'b0, 2'd0);
        check("sk_busy", {63'd0, busy}, 64'd1);
        check("sk_done", {63'd0, done}, 64'd1);
        step();
        check("sk_busy_end", {63'd0, busy}, 64'd0);
        check("sk_done_end", {63'd0, done}, 64'd0);
        check("sk_acc0", {28'd0, dut.acc_reg[0]}, 64'h20080);

        // mac_start into row 1, second mac_start while busy is ignored
        cmd(0, 16'h0100, 12'd5, 1'b1, 2'd1);
        step(); step();
        mac_start = 1'b1; px_val = 16'h7FFF; kern_addr = 12'd11; row_sel = 1'b0;
        step();
        mac_start = 1'b0;
        wait_done(cyc);
        check("bz_lat", 64'(cyc), 64'd15);
        step();
        check("bz_acc0", {28'd0, dut.acc_reg[0]}, 64'h20080);
        check("bz_acc1", {28'd0, dut.acc_reg[1]}, 64'h10080);
        check("bz_result", {32'd0, result_px}, 64'h0100_0200);
        step();
        check("bz_no_requeue", {63'd0, busy}, 64'd0);

        // Out-of-range row on the 3-row instance: done, nothing changes
        cmd(0, 16'h0100, 12'd5, 1'b1, 2'd3);
        wait_done(cyc);
        check("row3_done", {63'd0, done3}, 64'd1);
        check("row3_busy", {63'd0, busy3}, 64'd1);
        step();
        check("row3_acc0", {28'd0, dut3.acc_reg[0]}, 64'h20080);
        check("row3_acc1", {28'd0, dut3.acc_reg[1]}, 64'h10080);
        check("row3_acc2", {28'd0, dut3.acc_reg[2]}, 64'h80);
        check("row3_result", {16'd0, result_px3}, 64'h0000_0100_0200);
        check("row1_acc1", {28'd0, dut.acc_reg[1]}, 64'h20080);

        // Out-of-range kernel read returns 0 (the write there was dropped)
        cmd(2, 16'h0, 12'd3000, 1'b0, 2'd0);
        step();
        check("oor_bias", {48'd0, dut.bias_reg}, 64'h0);

        // Async reset, then negative kernel into row 1: 0x300 * -0x100
        rst = 1'b1;
        #1;
        check("ar_acc1", {28'd0, dut.acc_reg[1]}, 64'h0);
        step();
        rst = 1'b0;
        cmd(0, 16'h0300, 12'd9, 1'b1, 2'd1);
        wait_done(cyc);
        check("neg_lat", 64'(cyc), 64'd18);
        check("neg_done", {63'd0, done}, 64'd1);
        step();
        check("neg_acc1", {28'd0, dut.acc_reg[1]}, 64'hF_FFFD_0000);
        check("neg_result", {32'd0, result_px}, 64'hFD00_0000);

        // Reset during MUL_WAIT
        cmd(2, 16'h0, 12'd13, 1'b0, 2'd0);
        step();
        check("rw_bias_pre", {48'd0, dut.bias_reg}, 64'h1234);
        cmd(0, 16'h0100, 12'd5, 1'b0, 2'd0);
        step(); step(); step();
        check("rw_busy_pre", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("rw_busy", {63'd0, busy}, 64'd0);
        check("rw_bias", {48'd0, dut.bias_reg}, 64'h0);
        check("rw_acc1", {28'd0, dut.acc_reg[1]}, 64'h0);
        check("rw_result", {32'd0, result_px}, 64'h0);
        step();
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (done === 1'b1) dcount++;
        end
        check("rw_no_done", 64'(dcount), 64'd0);
        check("rw_acc0", {28'd0, dut.acc_reg[0]}, 64'h0);
        cmd(2, 16'h0, 12'd13, 1'b0, 2'd0);
        step();
        check("rw_kmem_kept", {48'd0, dut.bias_reg}, 64'h1234);

        // Accumulate 0x7FFF*0x7FFF (0x3FFF0001) into row 0
        for (int i = 0; i < 32; i++) begin
            cmd(0, 16'h7FFF, 12'd11, 1'b0, 2'd0);
            wait_done(cyc);
            step();
        end
        check("sat32_lat", 64'(cyc), 64'd18);
        check("sat32_acc0", {28'd0, dut.acc_reg[0]}, 64'h7_FFE0_0020);
        check("sat32_result", {48'd0, result_px[15:0]}, 64'h7FFF);
        check("sat32_flag", {62'd0, sat_flag}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            cmd(0, 16'h7FFF, 12'd11, 1'b0, 2'd0);
            wait_done(cyc);
            step();
        end
`ifdef MAC_ARRAY_SAT_EN
        check("sat40_acc0", {28'd0, dut.acc_reg[0]}, 64'h7_FFFF_FFFF);
        check("sat40_result", {48'd0, result_px[15:0]}, 64'h7FFF);
        check("sat40_flag", {62'd0, sat_flag}, 64'h1);
        check("sat40_flag3", {61'd0, sat_flag3}, 64'h1);
`else
        check("sat40_acc0", {28'd0, dut.acc_reg[0]}, 64'h9_FFD8_0028);
        check("sat40_result", {48'd0, result_px[15:0]}, 64'h8000);
        check("sat40_flag", {62'd0, sat_flag}, 64'h0);
        check("sat40_flag3", {61'd0, sat_flag3}, 64'h0);
`endif

        // mac_start_bias with zero pixel: presets rows, clears flags, skips
        cmd(1, 16'h0000, 12'd5, 1'b0, 2'd0);
        step();
        check("ib_done", {63'd0, done}, 64'd1);
        check("ib_acc0", {28'd0, dut.acc_reg[0]}, 64'h1234);
        check("ib_acc1", {28'd0, dut.acc_reg[1]}, 64'h1234);
        check("ib_flag", {62'd0, sat_flag}, 64'h0);
        check("ib_result", {32'd0, result_px}, 64'h0012_0012);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
